// File: rtl/tile_pkg.sv
// Shared constants for the tile renderer: grid geometry, tile-word layout,
// tile-state encoding and the colour palette.
package tile_pkg;

    localparam int GRID_COLS = 8;
    localparam int GRID_ROWS = 6;
    localparam int NUM_TILES = GRID_COLS * GRID_ROWS;

    // Tile word: [4:3] state, [2:0] face
    localparam int TILE_W       = 5;
    localparam int TW_STATE_MSB = 4;
    localparam int TW_STATE_LSB = 3;
    localparam int TW_FACE_MSB  = 2;
    localparam int TW_FACE_LSB  = 0;

    typedef enum logic [1:0] {
        ST_HIDDEN     = 2'd0,
        ST_REVEALED   = 2'd1,
        ST_MATCHED    = 2'd2,
        ST_HIDDEN_ALT = 2'd3
    } tile_state_e;

    localparam logic [23:0] COL_BLACK  = 24'h000000;
    localparam logic [23:0] COL_HIDDEN = 24'h404080;
    localparam logic [23:0] COL_BORDER = 24'h202020;
    localparam logic [23:0] COL_CURSOR = 24'hFFFFFF;

    function automatic logic [23:0] face_colour(input logic [2:0] face);
        logic [23:0] c;
        case (face)
            3'd0:    c = 24'hFF0000;
            3'd1:    c = 24'h00FF00;
            3'd2:    c = 24'h0000FF;
            3'd3:    c = 24'hFFFF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'h00FFFF;
            3'd6:    c = 24'hFF8000;
            default: c = 24'h8000FF;
        endcase
        return c;
    endfunction

    // Matched tiles are drawn at a quarter of the palette brightness
    function automatic logic [23:0] dim_quarter(input logic [23:0] c);
        return {2'b00, c[23:18], 2'b00, c[15:10], 2'b00, c[7:2]};
    endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// Tile-write request channel from game logic into the renderer's write FIFO.
interface tile_renderer_if;

    // A write transfers on every clock edge where wr_valid && wr_ready are both
    // high; the master holds wr_addr/wr_data stable while wr_valid waits on ready.
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_addr;
    logic [4:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/tile_wr_fifo.sv
// Small synchronous FIFO with registered full/empty flags, async active-low reset.
module tile_wr_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_full, r_empty;
    logic             w_do_push, w_do_pop;

    // A push into a full FIFO is honoured only when a pop frees the slot that cycle
    assign w_do_push = i_push && (!r_full || i_pop);
    assign w_do_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/tile_renderer.sv
// Two-stage tile-grid pixel colour pipeline with a vsync-gated tile write FIFO.
// Optional feature macro: TILE_CURSOR_BLINK_EN (cursor border blinks every 16 frames).
module tile_renderer
    import tile_pkg::*;
#(
    parameter int GRID_X0    = 64,
    parameter int GRID_Y0    = 48,
    parameter int TILE_LOG2  = 6,
    parameter int BORDER_W   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vga_clock,
    input  logic        resetn,
    input  logic [9:0]  xCoord,
    input  logic [9:0]  yCoord,
    input  logic        visible,
    input  logic        VGA_VS,
    input  logic [2:0]  cursor_col,
    input  logic [2:0]  cursor_row,
    tile_renderer_if.slave wr,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_tick
);

    localparam int                   TILE_PX = 1 << TILE_LOG2;
    localparam logic [9:0]           X0      = 10'(GRID_X0);
    localparam logic [9:0]           Y0      = 10'(GRID_Y0);
    localparam logic [9:0]           GRID_W  = 10'(GRID_COLS * TILE_PX);
    localparam logic [9:0]           GRID_H  = 10'(GRID_ROWS * TILE_PX);
    localparam logic [TILE_LOG2-1:0] B_LO    = TILE_LOG2'(BORDER_W);
    localparam logic [TILE_LOG2-1:0] B_HI    = TILE_LOG2'(TILE_PX - BORDER_W);

    // ---------------- stage 1: grid geometry ----------------
    logic [9:0]           w_gx, w_gy;
    logic [TILE_LOG2-1:0] w_ox, w_oy;
    logic [2:0]           w_col, w_row;
    logic                 w_in_grid, w_border, w_cursor_hit;

    assign w_gx         = xCoord - X0;
    assign w_gy         = yCoord - Y0;
    assign w_ox         = w_gx[TILE_LOG2-1:0];
    assign w_oy         = w_gy[TILE_LOG2-1:0];
    assign w_col        = w_gx[TILE_LOG2 +: 3];
    assign w_row        = w_gy[TILE_LOG2 +: 3];
    assign w_in_grid    = (w_gx < GRID_W) && (w_gy < GRID_H);
    assign w_border     = (w_ox < B_LO) || (w_ox >= B_HI) || (w_oy < B_LO) || (w_oy >= B_HI);
    assign w_cursor_hit = (w_col == cursor_col) && (w_row == cursor_row);

    logic       r_in_grid, r_border, r_cursor;
    logic [5:0] r_addr;

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_in_grid <= 1'b0;
            r_border  <= 1'b0;
            r_cursor  <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_in_grid <= w_in_grid;
            r_border  <= w_border;
            r_cursor  <= w_cursor_hit;
            r_addr    <= {w_row, w_col};
        end
    end

    // ---------------- write FIFO and tile RAM ----------------
    logic             w_push, w_pop, w_full, w_empty;
    logic [10:0]      w_fifo_q;
    logic [5:0]       w_pop_addr;
    logic [TILE_W-1:0] w_pop_data;

    assign w_push       = wr.wr_valid && wr.wr_ready;
    assign w_pop        = !VGA_VS && !w_empty;
    assign wr.wr_ready  = !w_full;
    assign w_pop_addr   = w_fifo_q[10:5];
    assign w_pop_data   = w_fifo_q[4:0];

    tile_wr_fifo #(
        .WIDTH (11),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (vga_clock),
        .rst_n   (resetn),
        .i_push  (w_push),
        .i_data  ({wr.wr_addr, wr.wr_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    logic [TILE_W-1:0] r_ram [NUM_TILES];

    // Out-of-range addresses are consumed from the FIFO but never written
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_TILES; i++) r_ram[i] <= '0;
        end else if (w_pop && (w_pop_addr < 6'(NUM_TILES))) begin
            r_ram[w_pop_addr] <= w_pop_data;
        end
    end

    // ---------------- frame tick / blink ----------------
    logic r_vs_d, r_tick, w_blink_on;

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_vs_d <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_vs_d <= VGA_VS;
            r_tick <= r_vs_d && !VGA_VS;
        end
    end

    assign frame_tick = r_tick;

`ifdef TILE_CURSOR_BLINK_EN
    logic [4:0] r_frame_cnt;

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn)     r_frame_cnt <= '0;
        else if (r_tick) r_frame_cnt <= r_frame_cnt + 5'd1;
    end

    assign w_blink_on = !r_frame_cnt[4];
`else
    assign w_blink_on = 1'b1;
`endif

    // ---------------- stage 2: colour ----------------
    logic [TILE_W-1:0] w_tile;
    tile_state_e       w_state;
    logic [23:0]       w_face_rgb, w_rgb_nxt, r_rgb;

    assign w_tile     = (r_addr < 6'(NUM_TILES)) ? r_ram[r_addr] : '0;
    assign w_state    = tile_state_e'(w_tile[TW_STATE_MSB:TW_STATE_LSB]);
    assign w_face_rgb = face_colour(w_tile[TW_FACE_MSB:TW_FACE_LSB]);

    always_comb begin
        w_rgb_nxt = COL_BLACK;
        if (!r_in_grid) begin
            w_rgb_nxt = COL_BLACK;
        end else if (r_border && r_cursor && w_blink_on) begin
            w_rgb_nxt = COL_CURSOR;
        end else if (r_border) begin
            w_rgb_nxt = COL_BORDER;
        end else begin
            case (w_state)
                ST_REVEALED: w_rgb_nxt = w_face_rgb;
                ST_MATCHED:  w_rgb_nxt = dim_quarter(w_face_rgb);
                default:     w_rgb_nxt = COL_HIDDEN;
            endcase
        end
    end

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) r_rgb <= '0;
        else         r_rgb <= w_rgb_nxt;
    end

    // visible is already delayed to match this stage, so the blanking AND stays combinational
    assign {VGA_R, VGA_G, VGA_B} = r_rgb & {24{visible}};

endmodule
